// File: rtl/s298_bist_pkg.sv
// ---------------------------------------------------------------------------
// s298_bist_pkg
// Shared definitions for the s298 response compactor (MISR) block:
//   - default signature width, feedback polynomial, seed and counter width
//   - the session FSM state enum
//   - bit positions of the s298 observation points inside the RESP bus
// No ports; imported by misr_step and s298_misr.
// ---------------------------------------------------------------------------
package s298_bist_pkg;

  // Default signature register geometry.
  // The polynomial is x^16+x^5+x^3+x^2+1 with the implicit x^16 term dropped.
  localparam int          SIG_W = 16;
  localparam logic [15:0] POLY  = 16'h002D;
  localparam logic [15:0] SEED  = 16'hFFFF;
  localparam int          CNT_W = 16;

  // Response bus layout: {G133,G132,G118,G117,G67,G66}, bit0 = G66.
  localparam int RESP_W    = 6;
  localparam int RESP_G66  = 0;
  localparam int RESP_G67  = 1;
  localparam int RESP_G117 = 2;
  localparam int RESP_G118 = 3;
  localparam int RESP_G132 = 4;
  localparam int RESP_G133 = 5;

  // Session FSM: wait for START, compact vectors, report for one cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/misr_step.sv
// ---------------------------------------------------------------------------
// misr_step
// One combinational step of the multiple-input signature register:
// shift left, fold the outgoing MSB back through the feedback polynomial,
// then XOR in the zero-extended circuit response.
// Ports:
//   sig_i   [SIG_W-1:0]   current signature
//   resp_i  [RESP_W-1:0]  circuit response vector
//   next_o  [SIG_W-1:0]   signature after compacting resp_i
// ---------------------------------------------------------------------------
module misr_step
  import s298_bist_pkg::*;
#(
  parameter int               SIG_W = s298_bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY  = s298_bist_pkg::POLY
) (
  input  logic [SIG_W-1:0]  sig_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [SIG_W-1:0]  next_o
);

  // The response is narrower than the signature, so it only disturbs the
  // low RESP_W bits; the upper bits see the plain shift/feedback.
  always_comb begin
    next_o = {sig_i[SIG_W-2:0], 1'b0}
           ^ (sig_i[SIG_W-1] ? POLY : '0)
           ^ {{(SIG_W-RESP_W){1'b0}}, resp_i};
  end

endmodule

// File: rtl/s298_misr.sv
// ---------------------------------------------------------------------------
// s298_misr
// Session controller around a MISR that compacts LEN valid s298 response
// vectors into a signature and compares it with a golden value.
// Ports:
//   CK          clock, rising edge
//   RST         synchronous active-high reset
//   START       session start request (only honoured in IDLE)
//   LEN         number of valid vectors to compact, latched at START
//   EXP_SIG     golden signature, latched at START
//   RESP_VALID  RESP carries a vector this cycle
//   RESP        {G133,G132,G118,G117,G67,G66}
//   BUSY        session in progress (RUN or CHECK)
//   DONE        one-cycle completion pulse
//   PASS        final signature matched EXP_SIG; held until next START/RST
//   SIGNATURE   current MISR contents
// ---------------------------------------------------------------------------
module s298_misr
  import s298_bist_pkg::*;
#(
  parameter int               SIG_W = s298_bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY  = s298_bist_pkg::POLY,
  parameter logic [SIG_W-1:0] SEED  = s298_bist_pkg::SEED,
  parameter int               CNT_W = s298_bist_pkg::CNT_W
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic [CNT_W-1:0]  LEN,
  input  logic [SIG_W-1:0]  EXP_SIG,
  input  logic              RESP_VALID,
  input  logic [RESP_W-1:0] RESP,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [SIG_W-1:0]  SIGNATURE
);

  state_e             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIG_W-1:0]   exp_q, exp_d;
  logic               pass_q, pass_d;
  logic [SIG_W-1:0]   stepNext;

  // Signature after compacting the vector on RESP this cycle.
  misr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) uStep (
    .sig_i  (sig_q),
    .resp_i (RESP),
    .next_o (stepNext)
  );

  // State registers. Reset wins over every other input, so a session in
  // flight is simply dropped without a DONE pulse.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic. Everything holds by default, which is what keeps the
  // final signature and PASS visible in IDLE and makes START/RESP_VALID
  // harmless outside the states that use them.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          sig_d  = SEED;
          cnt_d  = LEN;
          exp_d  = EXP_SIG;
          pass_d = 1'b0;
          if (LEN != '0) begin
            state_d = RUN;
          end else begin
            // Empty session: the seed is the final signature, so the
            // verdict can be formed right away for the CHECK cycle.
            state_d = CHECK;
            pass_d  = (SEED == EXP_SIG);
          end
        end
      end

      RUN: begin
        // cnt_q is never zero here (LEN==0 bypasses RUN), so the decrement
        // cannot wrap even for the all-ones length.
        if (RESP_VALID) begin
          sig_d = stepNext;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = CHECK;
            pass_d  = (stepNext == exp_q);
          end
        end
      end

      CHECK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY      = (state_q != IDLE);
  assign DONE      = (state_q == CHECK);
  assign PASS      = pass_q;
  assign SIGNATURE = sig_q;

endmodule

// File: doc/s298_misr.md
S298_MISR -- requirements
Module: s298_misr

Interface
REQ-001 SHALL have parameter SIG_W, default 16, signature width in bits.
REQ-002 SHALL have parameter POLY, default 16'h002D, feedback polynomial x^16+x^5+x^3+x^2+1 without the x^16 term.
REQ-003 SHALL have parameter SEED, default 16'hFFFF, signature value loaded at session start.
REQ-004 SHALL have parameter CNT_W, default 16, width of the session length.
REQ-005 SHALL use a single clock and a synchronous, active-high reset, with these ports:
- CK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous active-high reset
- START  in  1  session start request, sampled only in IDLE
- LEN  in  CNT_W  number of valid response vectors to compact, latched at START
- EXP_SIG  in  SIG_W  expected golden signature, latched at START
- RESP_VALID  in  1  RESP is valid this cycle
- RESP  in  6  circuit response {G133,G132,G118,G117,G67,G66}, bit0=G66
- BUSY  out  1  session in progress (RUN or CHECK)
- DONE  out  1  one-cycle pulse, session complete
- PASS  out  1  final signature equals latched EXP_SIG
- SIGNATURE  out  SIG_W  current MISR contents

Function
REQ-006 SHALL implement the FSM states IDLE, RUN and CHECK.
REQ-007 IDLE with START=1 SHALL load sig=SEED, cnt=LEN and exp_q=EXP_SIG, and clear PASS.
REQ-008 From IDLE with START=1, the next state SHALL be RUN when LEN!=0 and CHECK when LEN==0.
REQ-009 A MISR step SHALL compute next = (sig<<1) XOR (sig[SIG_W-1] ? POLY : 0) XOR zero-extended RESP.
REQ-010 In RUN, each cycle with RESP_VALID=1 SHALL perform one step and decrement cnt; cycles with RESP_VALID=0 SHALL hold sig and cnt.
REQ-011 In RUN, a valid cycle with cnt==1 SHALL be compacted and SHALL move the FSM to CHECK.
REQ-012 CHECK SHALL last exactly one cycle with DONE=1 and SHALL then return to IDLE.
REQ-013 Latency: DONE SHALL be high in the cycle immediately after the last compacted vector was sampled.
REQ-014 PASS SHALL be registered as (next sig == exp_q) on entry to CHECK, SHALL be visible coincident with DONE, and SHALL hold until the next accepted START or RST.
REQ-015 SIGNATURE SHALL hold its final value in IDLE until the next accepted START.
REQ-016 START while BUSY SHALL be ignored, including START in CHECK.
REQ-017 RESP_VALID in IDLE or CHECK SHALL be ignored.
REQ-018 BUSY SHALL be 1 in RUN and CHECK and 0 in IDLE.
REQ-019 cnt SHALL never wrap; LEN=2^CNT_W-1 SHALL compact exactly that many vectors.

Reset
REQ-020 RST SHALL override all other inputs in the same cycle, including START and RESP_VALID.
REQ-021 After RST: state=IDLE, SIGNATURE=SEED, cnt=0, exp_q=0, BUSY=0, DONE=0, PASS=0.
REQ-022 RST mid-session SHALL abort the session with no DONE pulse.

Structure
REQ-023 Package s298_bist_pkg SHALL hold SIG_W, POLY, SEED, CNT_W, the state enum and the RESP bit-order constants.
REQ-024 The MISR step SHALL be a combinational sub-module misr_step (sig, resp -> next); FSM, counter and compare SHALL stay in s298_misr.

Verification
REQ-025 Reset, then START with LEN=1, EXP_SIG=16'hFFD3, and one valid cycle with RESP=6'h00 -> SIGNATURE=16'hFFD3, DONE one cycle, PASS=1.
REQ-026 Same session with RESP=6'h3F and EXP_SIG=16'hFFD3 -> SIGNATURE=16'hFFEC, PASS=0.
REQ-027 START with LEN=0 -> no step, DONE the next cycle, SIGNATURE=16'hFFFF, PASS=(EXP_SIG==16'hFFFF).
REQ-028 LEN=4 with RESP_VALID gapped (1,0,0,1,1,0,1) -> exactly 4 steps; signature equals the golden model; DONE after the 7th cycle.
REQ-029 START during RUN and RESP_VALID in IDLE -> no effect on cnt, sig or exp_q.
REQ-030 RST asserted in RUN together with START and RESP_VALID -> IDLE, SIGNATURE=16'hFFFF, no DONE; a fresh session then completes normally.
